// File: rtl/mem_responder.sv
// Word-array memory model with an in-order, latency-stamped read return queue.
// Reads capture array data at accept; responses leave in accept order once due.
module mem_responder #(
  parameter int MEM_ADDR_SIZE = 16,
  parameter int MEM_BANDWIDTH = 4,
  parameter int DEPTH         = 4096,
  parameter int QUEUE_DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_valid,
  input  logic [MEM_ADDR_SIZE-1:0]   mem_addr,
  input  logic                       mem_write_valid,
  input  logic [MEM_BANDWIDTH*8-1:0] mem_write_data,
  input  logic [3:0]                 cfg_latency,
  output logic                       mem_req_ready,
  output logic [MEM_BANDWIDTH*8-1:0] mem_data,
  output logic                       mem_valid,
  output logic                       mem_err
);

  localparam int DW = MEM_BANDWIDTH * 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [MEM_ADDR_SIZE:0] DEPTH_LIM = (MEM_ADDR_SIZE+1)'(DEPTH);
  localparam logic [PW:0]            FULL_CNT  = (PW+1)'(QUEUE_DEPTH);

  logic [DW-1:0] memArray [DEPTH];

  logic [DW-1:0] qData_q [QUEUE_DEPTH];
  logic          qErr_q  [QUEUE_DEPTH];
  logic [7:0]    qDue_q  [QUEUE_DEPTH];

  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    now_q;
  logic          memValid_q, memErr_q;
  logic [DW-1:0] memData_q;

  logic          inRange;
  logic [IW-1:0] memIdx;
  logic [DW-1:0] readWord;
  logic [3:0]    effLat;
  logic [7:0]    dueStamp;
  logic [7:0]    headAge;
  logic          full, push, pop;

  assign inRange       = {1'b0, mem_addr} < DEPTH_LIM;
  assign memIdx        = mem_addr[IW-1:0];
  assign readWord      = inRange ? memArray[memIdx] : '0;
  assign effLat        = (cfg_latency == 4'd0) ? 4'd1 : cfg_latency;
  assign dueStamp      = now_q + {4'd0, effLat};
  assign full          = (count_q == FULL_CNT);
  assign mem_req_ready = !full;
  assign push          = mem_read_valid && !full;

  // Head is due when now has reached its stamp within the forward half of the 8-bit ring.
  assign headAge       = now_q - qDue_q[rdPtr_q];
  assign pop           = (count_q != '0) && !headAge[7];

  assign mem_valid = memValid_q;
  assign mem_err   = memErr_q;
  assign mem_data  = memData_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_write_valid && inRange) begin
      memArray[memIdx] <= mem_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qData_q[wrPtr_q] <= readWord;
      qErr_q[wrPtr_q]  <= !inRange;
      qDue_q[wrPtr_q]  <= dueStamp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q      <= '0;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      memValid_q <= 1'b0;
      memErr_q   <= 1'b0;
      memData_q  <= '0;
    end else begin
      now_q      <= now_q + 8'd1;
      count_q    <= count_d;
      memValid_q <= pop;
      if (push) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q   <= rdPtr_q + PW'(1);
        memData_q <= qData_q[rdPtr_q];
        memErr_q  <= qErr_q[rdPtr_q];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// compared against an absolute-time queue model of the read return path.
module tb_mem_responder;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int QD    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdValid = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          wrValid = 1'b0;
  logic [DW-1:0] wrData = '0;
  logic [3:0]    cfgLat = 4'd1;
  logic          mem_req_ready, mem_valid, mem_err;
  logic [DW-1:0] mem_data;

  mem_responder #(
    .MEM_ADDR_SIZE(AW), .MEM_BANDWIDTH(4), .DEPTH(DEPTH), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read_valid(rdValid), .mem_addr(addr),
    .mem_write_valid(wrValid), .mem_write_data(wrData),
    .cfg_latency(cfgLat),
    .mem_req_ready(mem_req_ready), .mem_data(mem_data),
    .mem_valid(mem_valid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Model: each queued read carries the absolute edge index at which it becomes due.
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } resp_t;

  resp_t         refQ[$];
  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] lastData = '0;
  int            edgeNum = 0;
  int            checkCount = 0;
  int            failCount = 0;
  bit            acc;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h expected 0x%0h",
               tag, edgeNum, observed, expected);
    end
  endtask

  // One clock: predict the edge from the model, let it happen, then compare.
  task automatic tick(output bit accepted);
    resp_t head;
    resp_t r;
    bit    popNow;
    int    lat;
    if (rst) refQ.delete();
    checkOutput("ready", {31'b0, mem_req_ready}, {31'b0, (refQ.size() < QD)});
    accepted = !rst && rdValid && (refQ.size() < QD);
    popNow   = !rst && (refQ.size() > 0) && (refQ[0].due <= edgeNum);
    if (popNow) head = refQ.pop_front();
    if (accepted) begin
      lat    = (cfgLat == 4'd0) ? 1 : int'(cfgLat);
      r.err  = (int'(addr) >= DEPTH);
      r.data = r.err ? '0 : refMem[addr];
      r.due  = edgeNum + lat;
      refQ.push_back(r);
    end
    if (!rst && wrValid && int'(addr) < DEPTH) refMem[addr] = wrData;
    @(posedge clk);
    edgeNum++;
    #1;
    checkOutput("valid", {31'b0, mem_valid}, {31'b0, popNow});
    if (popNow) begin
      lastData = head.data;
      checkOutput("err", {31'b0, mem_err}, {31'b0, head.err});
    end
    if (rst) lastData = '0;
    checkOutput("data", mem_data, lastData);
  endtask

  task automatic applyStimulus(input bit rv, input logic [AW-1:0] a, input bit wv,
                               input logic [DW-1:0] wd, input logic [3:0] lat,
                               output bit accepted);
    rdValid = rv;
    addr    = a;
    wrValid = wv;
    wrData  = wd;
    cfgLat  = lat;
    tick(accepted);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 4'd1, a);
  endtask

  task automatic doReset(input int n);
    bit a;
    rdValid = 1'b0;
    wrValid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick(a);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    doReset(2);

    for (int i = 0; i < 64; i++)
      applyStimulus(1'b0, 16'(i), 1'b1, (i == 7) ? 32'h0 : 32'($urandom), 4'd1, acc);

    // Basic read after write
    applyStimulus(1'b0, 16'd5, 1'b1, 32'hDEADBEEF, 4'd3, acc);
    applyStimulus(1'b1, 16'd5, 1'b0, '0, 4'd3, acc);
    idle(6);

    // Full queue: retry each read until the responder takes it
    for (int i = 0; i < 20; i++) begin
      int tries = 0;
      acc = 1'b0;
      while (!acc && tries < 64) begin
        applyStimulus(1'b1, 16'(i), 1'b0, '0, 4'd15, acc);
        tries++;
      end
      checkOutput("fullAccept", {31'b0, acc}, 32'd1);
    end
    idle(40);

    // Read-before-write on the same address
    applyStimulus(1'b1, 16'd7, 1'b1, 32'h1, 4'd2, acc);
    applyStimulus(1'b1, 16'd7, 1'b0, '0, 4'd2, acc);
    idle(6);

    // Latency reduction keeps order
    applyStimulus(1'b1, 16'd10, 1'b0, '0, 4'd10, acc);
    applyStimulus(1'b1, 16'd11, 1'b0, '0, 4'd1, acc);
    idle(14);

    // Out of range read and dropped out of range write
    applyStimulus(1'b1, 16'(DEPTH), 1'b0, '0, 4'd0, acc);
    applyStimulus(1'b0, 16'(DEPTH), 1'b1, 32'hFFFFFFFF, 4'd1, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(i), 1'b0, '0, 4'd2, acc);
    idle(6);

    // Reset with reads outstanding, then wrap the cycle counter
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(i), 1'b0, '0, 4'd15, acc);
    doReset(2);
    idle(300);
    applyStimulus(1'b1, 16'd5, 1'b0, '0, 4'd4, acc);
    idle(8);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 299) == 0) doReset(2);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                      : 16'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 99) < 60, a, $urandom_range(0, 99) < 30,
                    32'($urandom), 4'($urandom_range(0, 15)), acc);
    end

    for (int i = 0; i < 300 && refQ.size() > 0; i++) idle(1);
    checkOutput("drain", 32'(refQ.size()), 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
